// File: rtl/single_port_ram_if.sv
// Bus bundle for the single-port RAM: one shared address, write enable,
// write data and the registered read data coming back.
interface single_port_ram_if #(
  parameter int data_width = 8,
  parameter int addr_width = 4
);

  logic                  we;
  logic [addr_width-1:0] addr;
  logic [data_width-1:0] data_in;
  logic [data_width-1:0] data_out;

  // Requester side: issues operations, observes read data.
  modport master (
    output we,
    output addr,
    output data_in,
    input  data_out
  );

  // Memory side: accepts operations, returns read data.
  modport slave (
    input  we,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/single_port_ram.sv
// Synchronous single-port RAM with a registered, write-first read port.
// The asynchronous reset clears the whole array and the output register,
// so locations never written since reset always read back as zero.
module single_port_ram #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic               clk,
  input  logic               rst,
  single_port_ram_if.slave   bus
);

  localparam int depth = 1 << addr_width;

  logic [data_width-1:0] mem_r [depth];
  logic [data_width-1:0] data_out_r;
  logic [data_width-1:0] next_out_s;

  // Select the value the output register loads: write data wins on a write.
  always_comb begin
    next_out_s = {data_width{1'b0}};
    if (bus.we) begin
      next_out_s = bus.data_in;
    end else begin
      next_out_s = mem_r[bus.addr];
    end
  end

  // Storage array: cleared by reset, written on enabled edges only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_r[i[addr_width-1:0]] <= {data_width{1'b0}};
      end
    end else begin
      if (bus.we) begin
        mem_r[bus.addr] <= bus.data_in;
      end
    end
  end

  // Output register: reloaded on every non-reset edge, no hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r <= {data_width{1'b0}};
    end else begin
      data_out_r <= next_out_s;
    end
  end

  assign bus.data_out = data_out_r;

endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_single_port_ram;

  logic clk;
  logic rst;

  single_port_ram_if #(.data_width(8), .addr_width(4)) ram_bus ();

  single_port_ram #(.data_width(8), .addr_width(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ram_bus)
  );

  // Reference model: plain memory array plus expected output value.
  logic [7:0] model_mem [16];
  logic [7:0] model_out;

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_out = 8'h00;
  endtask

  // One operation: drive inputs, take the edge, update model, check at negedge.
  task automatic do_op(input string tag, input logic we_i, input logic [3:0] a, input logic [7:0] d);
    ram_bus.we      = we_i;
    ram_bus.addr    = a;
    ram_bus.data_in = d;
    @(posedge clk);
    if (we_i) begin
      model_mem[a] = d;
      model_out    = d;
    end else begin
      model_out = model_mem[a];
    end
    @(negedge clk);
    check_eq(tag, ram_bus.data_out, model_out);
  endtask

  task automatic pulse_reset_between_edges();
    // Called at a negedge: assert reset well before the next rising edge.
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_immediate", ram_bus.data_out, 8'h00);
    // Hold reset over a rising edge with a write pending; it must be ignored.
    ram_bus.we      = 1'b1;
    ram_bus.addr    = 4'd0;
    ram_bus.data_in = 8'hFF;
    @(posedge clk);
    #1;
    check_eq("rst_held_edge", ram_bus.data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst             = 1'b1;
    ram_bus.we      = 1'b0;
    ram_bus.addr    = 4'd0;
    ram_bus.data_in = 8'h00;
    model_clear();
    #12;
    check_eq("reset_state", ram_bus.data_out, 8'h00);
    rst = 1'b0;

    // Reset check: unwritten locations read zero.
    do_op("rst_read0",  1'b0, 4'd0,  8'h00);
    do_op("rst_read5",  1'b0, 4'd5,  8'h00);
    do_op("rst_read15", 1'b0, 4'd15, 8'h00);

    // Write/readback with write-first output.
    do_op("wr0", 1'b1, 4'd0, 8'hA5);
    do_op("wr1", 1'b1, 4'd1, 8'h56);
    do_op("wr2", 1'b1, 4'd2, 8'hB4);
    do_op("rd0", 1'b0, 4'd0, 8'h00);
    do_op("rd1", 1'b0, 4'd1, 8'h00);
    do_op("rd2", 1'b0, 4'd2, 8'h00);

    // Overwrite: last write wins, neighbour untouched.
    do_op("ow_a",  1'b1, 4'd3, 8'h11);
    do_op("ow_b",  1'b1, 4'd3, 8'h22);
    do_op("ow_rd", 1'b0, 4'd3, 8'h00);
    do_op("ow_nb", 1'b0, 4'd2, 8'h00);

    // Full-depth sweep with addr ^ 0x3C.
    for (int i = 0; i < 16; i++) do_op("sweep_wr", 1'b1, 4'(i), 8'(i) ^ 8'h3C);
    for (int i = 0; i < 16; i++) do_op("sweep_rd", 1'b0, 4'(i), 8'h00);
    check_eq("sweep_a15", model_out, 8'h33);

    // Async reset mid-operation, then everything reads zero.
    pulse_reset_between_edges();
    do_op("post_rst0", 1'b0, 4'd0, 8'h00);
    do_op("post_rst1", 1'b0, 4'd1, 8'h00);
    do_op("post_rst2", 1'b0, 4'd2, 8'h00);

    // Read-after-write on the same address.
    do_op("raw_wr", 1'b1, 4'd9, 8'h7E);
    do_op("raw_rd", 1'b0, 4'd9, 8'h00);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      if (n % 150 == 149) pulse_reset_between_edges();
      do_op("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)));
    end

    // Final readback of the whole array against the model.
    for (int i = 0; i < 16; i++) do_op("final_rd", 1'b0, 4'(i), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
